// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF, MEM-stage and memory-side signals of the unified memory port arbiter.
// slave is the arbiter's view; master is the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_read;
  logic              dm_write;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_mem;
  logic              timeout_err;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, timeout_err
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Data-priority arbiter for a single-port memory shared by IF and MEM, with IF starvation guard and timeout.
// Best case one access per 3 cycles; requesters hold their request (stalled) until a one-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int DATA_MAX_CONSEC = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cons_cnt, cons_cnt_nxt;
  logic [7:0]        tmo_cnt, tmo_cnt_nxt;
  logic              mem_req_nxt, mem_we_nxt;
  logic              if_ack_nxt, dm_ack_nxt, timeout_err_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;
  logic              dm_pend, starve_if, tmo_hit;

  assign dm_pend       = bus.dm_read | bus.dm_write;
  assign starve_if     = (cons_cnt == 4'(DATA_MAX_CONSEC));
  assign tmo_hit       = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign bus.stall_if  = bus.if_req & ~bus.if_ack;
  assign bus.stall_mem = dm_pend & ~bus.dm_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cons_cnt        <= '0;
      tmo_cnt         <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.if_ack      <= 1'b0;
      bus.dm_ack      <= 1'b0;
      bus.if_rdata    <= '0;
      bus.dm_rdata    <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      state           <= state_nxt;
      cons_cnt        <= cons_cnt_nxt;
      tmo_cnt         <= tmo_cnt_nxt;
      bus.mem_req     <= mem_req_nxt;
      bus.mem_we      <= mem_we_nxt;
      bus.mem_addr    <= mem_addr_nxt;
      bus.mem_wdata   <= mem_wdata_nxt;
      bus.if_ack      <= if_ack_nxt;
      bus.dm_ack      <= dm_ack_nxt;
      bus.if_rdata    <= if_rdata_nxt;
      bus.dm_rdata    <= dm_rdata_nxt;
      bus.timeout_err <= timeout_err_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cons_cnt_nxt    = cons_cnt;
    tmo_cnt_nxt     = tmo_cnt;
    mem_req_nxt     = bus.mem_req;
    mem_we_nxt      = bus.mem_we;
    mem_addr_nxt    = bus.mem_addr;
    mem_wdata_nxt   = bus.mem_wdata;
    if_ack_nxt      = bus.if_ack;
    dm_ack_nxt      = bus.dm_ack;
    if_rdata_nxt    = bus.if_rdata;
    dm_rdata_nxt    = bus.dm_rdata;
    timeout_err_nxt = bus.timeout_err;

    case (state)
      IDLE: begin
        // IF wins only when data is idle or data has used up its consecutive-grant allowance
        if (bus.if_req && (!dm_pend || starve_if)) begin
          state_nxt    = GNT_I;
          mem_addr_nxt = bus.if_addr;
          mem_we_nxt   = 1'b0;
          mem_req_nxt  = 1'b1;
          cons_cnt_nxt = '0;
        end else if (dm_pend) begin
          state_nxt     = GNT_D;
          mem_addr_nxt  = bus.dm_addr;
          mem_wdata_nxt = bus.dm_wdata;
          mem_we_nxt    = bus.dm_write;
          mem_req_nxt   = 1'b1;
          cons_cnt_nxt  = bus.if_req ? cons_cnt + 4'd1 : 4'd0;
        end
      end
      GNT_D, GNT_I: begin
        // A watchdog expiry completes the access like a normal one, but with zero read data
        if (bus.mem_ready || tmo_hit) begin
          state_nxt   = DONE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          if (state == GNT_I) begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = bus.mem_ready ? bus.mem_rdata : '0;
          end else begin
            dm_ack_nxt = 1'b1;
            if (!bus.mem_we) dm_rdata_nxt = bus.mem_ready ? bus.mem_rdata : '0;
          end
          if (!bus.mem_ready) timeout_err_nxt = 1'b1;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
        end
      end
      DONE: begin
        // Requesters still show the request they were just acked for, so skip arbitration here
        if_ack_nxt  = 1'b0;
        dm_ack_nxt  = 1'b0;
        tmo_cnt_nxt = '0;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and randomized accesses against a word-array memory and
// a reference store image; grant order under contention is predicted from the 4-data-then-1-IF rule.
module tb_mem_port_arbiter;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  logic [31:0] ref_mem   [256];
  logic [31:0] mem_array [256];
  logic [31:0] last_dm;
  int          mem_lat;
  bit          mem_stuck;
  int          wait_cnt;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .DATA_MAX_CONSEC(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Memory model: answers mem_req after mem_lat extra cycles, unless stuck.
  initial begin
    wait_cnt      = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (bus.mem_req && !mem_stuck) begin
        if (wait_cnt >= mem_lat) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_we) begin
            mem_array[bus.mem_addr[9:2]] = bus.mem_wdata;
            bus.mem_rdata = 32'($urandom);
          end else begin
            bus.mem_rdata = mem_array[bus.mem_addr[9:2]];
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt      = 0;
        bus.mem_rdata = 32'($urandom);
      end
    end
  end

  // kind: 0 fetch, 1 load, 2 store, 3 load+store (acts as store)
  task automatic access(input int kind, input logic [7:0] widx, input logic [31:0] wd,
                        input int lat, input bit tmo);
    logic [31:0] a;
    logic [31:0] exp_rd;
    int  n;
    bit  got, seen_req, is_wr;
    a         = {22'd0, widx, 2'b00};
    is_wr     = (kind >= 2);
    mem_lat   = lat;
    mem_stuck = tmo;
    @(negedge clk);
    if (kind == 0) begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end else begin
      bus.dm_read  = (kind == 1 || kind == 3);
      bus.dm_write = is_wr;
      bus.dm_addr  = a;
      bus.dm_wdata = wd;
    end
    n = 0; got = 0; seen_req = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.mem_req && !seen_req) begin
        seen_req = 1;
        chk("grant_we", bus.mem_we, is_wr);
        chk("grant_addr", bus.mem_addr, a);
        if (is_wr) chk("grant_wdata", bus.mem_wdata, wd);
        // the grant must not track requester inputs once latched
        if (kind == 0) bus.if_addr = 32'($urandom);
        else begin bus.dm_addr = 32'($urandom); bus.dm_wdata = 32'($urandom); end
      end
      if (bus.if_ack || bus.dm_ack) got = 1;
    end
    chk("ack_seen", got, 1'b1);
    if (got) begin
      chk("latency", n, tmo ? TMO + 1 : lat + 2);
      chk("req_low_in_ack", bus.mem_req, 1'b0);
      if (kind == 0) begin
        exp_rd = tmo ? 32'h0 : ref_mem[widx];
        chk("if_ack_only", {bus.if_ack, bus.dm_ack}, 2'b10);
        chk("if_rdata", bus.if_rdata, exp_rd);
        chk("stall_if_in_ack", bus.stall_if, 1'b0);
      end else begin
        if (!is_wr) last_dm = tmo ? 32'h0 : ref_mem[widx];
        chk("dm_ack_only", {bus.if_ack, bus.dm_ack}, 2'b01);
        chk("dm_rdata", bus.dm_rdata, last_dm);
        chk("stall_mem_in_ack", bus.stall_mem, 1'b0);
      end
    end
    if (is_wr && !tmo) ref_mem[widx] = wd;
    bus.if_req = 1'b0; bus.dm_read = 1'b0; bus.dm_write = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {bus.if_ack, bus.dm_ack}, 2'b00);
    mem_stuck = 0;
  endtask

  initial begin
    int k, n, kind;
    logic [7:0] ia, da;
    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_read = 1'b0; bus.dm_write = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    mem_lat = 0; mem_stuck = 0; last_dm = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 32'($urandom);
      mem_array[i] = ref_mem[i];
    end

    #12;
    chk("reset_ctrl", {bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.timeout_err}, 5'b0);
    chk("reset_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 64'h0);
    chk("reset_rdata", {bus.if_rdata, bus.dm_rdata}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    access(0, 8'h10, 32'h0, 0, 0);
    access(2, 8'h40, 32'hDEADBEEF, 1, 0);
    access(1, 8'h40, 32'h0, 0, 0);
    chk("load_back", bus.dm_rdata, 32'hDEADBEEF);
    access(3, 8'h41, 32'h12345678, 0, 0);
    access(1, 8'h41, 32'h0, 2, 0);

    for (int i = 0; i < 24; i++) begin
      kind = int'($urandom_range(0, 3));
      access(kind, 8'($urandom), 32'($urandom), int'($urandom_range(0, 3)), 0);
    end
    chk("no_timeout_yet", bus.timeout_err, 1'b0);

    // both requesters held: expect D,D,D,D,I repeating
    mem_lat = int'($urandom_range(0, 2));
    @(negedge clk);
    ia = 8'($urandom); da = 8'($urandom);
    bus.if_req = 1'b1; bus.if_addr = {22'd0, ia, 2'b00};
    bus.dm_read = 1'b1; bus.dm_write = 1'b0; bus.dm_addr = {22'd0, da, 2'b00};
    k = 0; n = 0;
    while (k < 15 && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.if_ack || bus.dm_ack) begin
        chk("cont_one_ack", bus.if_ack & bus.dm_ack, 1'b0);
        chk("cont_order", bus.if_ack, (k % 5) == 4);
        if (bus.if_ack) begin
          chk("cont_if_rdata", bus.if_rdata, ref_mem[ia]);
          ia = 8'($urandom); bus.if_addr = {22'd0, ia, 2'b00};
        end else begin
          chk("cont_dm_rdata", bus.dm_rdata, ref_mem[da]);
          last_dm = ref_mem[da];
          da = 8'($urandom); bus.dm_addr = {22'd0, da, 2'b00};
        end
        mem_lat = int'($urandom_range(0, 2));
        k++;
      end
    end
    chk("cont_count", k, 15);
    bus.if_req = 1'b0; bus.dm_read = 1'b0;
    @(negedge clk);

    access(1, 8'h22, 32'h0, 0, 1);
    chk("timeout_set", bus.timeout_err, 1'b1);
    access(0, 8'h23, 32'h0, 0, 1);
    access(2, 8'h24, 32'hA5A5_0F0F, 1, 0);
    access(1, 8'h24, 32'h0, 0, 0);
    chk("timeout_sticky", bus.timeout_err, 1'b1);

    // reset in the middle of a stalled store grant
    mem_stuck = 1;
    @(negedge clk);
    bus.dm_write = 1'b1; bus.dm_addr = 32'h200; bus.dm_wdata = 32'hCAFEF00D;
    repeat (3) @(negedge clk);
    chk("pre_rst_grant", {bus.mem_req, bus.mem_we}, 2'b11);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_ctrl", {bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.timeout_err}, 5'b0);
    chk("rst_mid_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 64'h0);
    chk("rst_mid_rdata", {bus.if_rdata, bus.dm_rdata}, 64'h0);
    bus.dm_write = 1'b0; mem_stuck = 0; last_dm = '0;
    @(negedge clk);
    rst = 1'b1;
    access(0, 8'h80, 32'h0, 0, 0);
    chk("post_rst_no_err", bus.timeout_err, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
